// File: rtl/digi_ota_if.sv
// Bus bundle for digi_ota_array: run/clear controls, differential inputs and
// per-channel drive, enable, integrator and saturation results.
interface digi_ota_if #(
  parameter int CH    = 2,
  parameter int CNT_W = 8
);
  logic                  en;
  logic                  clr;
  logic [CH-1:0]         vip;
  logic [CH-1:0]         vin;
  logic [CH-1:0]         out;
  logic [CH-1:0]         out_en;
  logic [CH*CNT_W-1:0]   integ;
  logic [CH-1:0]         sat;

  modport master (output en, clr, vip, vin, input out, out_en, integ, sat);
  modport slave  (input en, clr, vip, vin, output out, out_en, integ, sat);
endinterface

// File: rtl/digi_ota_array.sv
// CH-channel clocked digital OTA: synchronise vip/vin, filter the decision,
// drive out/out_en and integrate into a saturating counter. Define DIGI_OTA_LEAK_EN for integrator leakage.
module digi_ota_array #(
  parameter int CH    = 2,
  parameter int CNT_W = 8,
  parameter int FILT  = 2
) (
  input logic       clk,
  input logic       rst_n,
  digi_ota_if.slave bus
);
  typedef enum logic [1:0] {DEC_HOLD = 2'd0, DEC_HIGH = 2'd1, DEC_LOW = 2'd2} dec_t;

  localparam int RC_W = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic signed [CNT_W-1:0] INT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] INT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] ONE     = 1;

  function automatic logic signed [CNT_W-1:0] integ_step(
    input logic signed [CNT_W-1:0] v,
    input dec_t                    d
  );
    logic signed [CNT_W-1:0] r;
    r = v;
    case (d)
      DEC_HIGH: if (v != INT_MAX) r = v + ONE;
      DEC_LOW:  if (v != INT_MIN) r = v - ONE;
      default: begin
`ifdef DIGI_OTA_LEAK_EN
        if (v > 0)      r = v - ONE;
        else if (v < 0) r = v + ONE;
`endif
      end
    endcase
    return r;
  endfunction

  logic [CH-1:0]       vip_s1, vip_s2, vin_s1, vin_s2;
  logic [CH-1:0]       out_v, oe_v, sat_v;
  logic [CH*CNT_W-1:0] integ_v;

  // Two-flop synchroniser keeps sampling regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vip_s1 <= '0;
      vip_s2 <= '0;
      vin_s1 <= '0;
      vin_s2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so
      // s2 really lags s1 by one cycle; blocking here would collapse the chain.
      vip_s1 <= bus.vip;
      vip_s2 <= vip_s1;
      vin_s1 <= bus.vin;
      vin_s2 <= vin_s1;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    dec_t                    raw, acc, pend, acc_nxt, pend_nxt;
    logic [RC_W-1:0]         rc, rc_nxt;
    logic                    out_q, oe_q;
    logic signed [CNT_W-1:0] integ_q;

    always_comb begin
      if (vip_s2[g] == vin_s2[g]) raw = DEC_HOLD;
      else if (vip_s2[g])         raw = DEC_HIGH;
      else                        raw = DEC_LOW;
    end

    // A run of identical raw decisions differing from acc is accepted once it
    // reaches FILT cycles; returning to acc abandons the pending run.
    always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise a
      // missed branch infers a latch.
      acc_nxt  = acc;
      pend_nxt = pend;
      rc_nxt   = rc;
      if (raw == acc) begin
        pend_nxt = acc;
        rc_nxt   = '0;
      end else if (raw != pend) begin
        pend_nxt = raw;
        rc_nxt   = '0;
        if (FILT == 1) acc_nxt = raw;
      end else if (int'(rc) + 2 >= FILT) begin
        acc_nxt = raw;
        rc_nxt  = '0;
      end else begin
        rc_nxt = rc + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc     <= DEC_HOLD;
        pend    <= DEC_HOLD;
        rc      <= '0;
        out_q   <= 1'b0;
        oe_q    <= 1'b0;
        integ_q <= '0;
      end else begin
        if (bus.clr)     integ_q <= '0;
        else if (bus.en) integ_q <= integ_step(integ_q, acc);
        if (bus.en) begin
          acc  <= acc_nxt;
          pend <= pend_nxt;
          rc   <= rc_nxt;
          oe_q <= (acc_nxt != DEC_HOLD);
          if (acc_nxt == DEC_HIGH)     out_q <= 1'b1;
          else if (acc_nxt == DEC_LOW) out_q <= 1'b0;
        end
      end
    end

    assign out_v[g]                 = out_q;
    assign oe_v[g]                  = oe_q;
    assign integ_v[g*CNT_W +: CNT_W] = integ_q;
    assign sat_v[g]                 = (integ_q == INT_MAX) || (integ_q == INT_MIN);
  end

  assign bus.out    = out_v;
  assign bus.out_en = oe_v;
  assign bus.integ  = integ_v;
  assign bus.sat    = sat_v;
endmodule

// File: tb/tb_digi_ota_array.sv
// Self-checking bench for digi_ota_array: directed table, control sequences
// and randomized stimulus against a history-based reference model.
module tb_digi_ota_array;
  localparam int CH = 2, CNT_W = 4, FILT = 2;
  localparam int IMAX = 7, IMIN = -8;
`ifdef DIGI_OTA_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif

  typedef enum int {D_HOLD, D_HIGH, D_LOW} dec_e;
  typedef struct {
    logic [1:0] vip, vin;
    logic [1:0] out, oe, sat;
    int         i0, i1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  digi_ota_if #(.CH(CH), .CNT_W(CNT_W)) bus ();
  digi_ota_array #(.CH(CH), .CNT_W(CNT_W), .FILT(FILT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Reference model: delay line for the synchroniser, a history of the last
  // FILT enabled raw decisions, and integer integrators.
  logic [CH-1:0] m_p1, m_p2, m_n1, m_n2;
  dec_e          m_acc[CH];
  dec_e          m_hist[CH][$];
  logic          m_out[CH], m_oe[CH];
  int            m_int[CH];

  function automatic dec_e decide(input logic p, input logic n);
    if (p == n) return D_HOLD;
    return p ? D_HIGH : D_LOW;
  endfunction

  function automatic int int_step(input int v, input dec_e d);
    if (d == D_HIGH) return (v < IMAX) ? v + 1 : v;
    if (d == D_LOW)  return (v > IMIN) ? v - 1 : v;
    if (LEAK) return (v > 0) ? v - 1 : (v < 0) ? v + 1 : v;
    return v;
  endfunction

  function automatic int integ_of(input int ch);
    logic signed [CNT_W-1:0] t;
    t = bus.integ[ch*CNT_W +: CNT_W];
    return int'(t);
  endfunction

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_n1 = '0; m_n2 = '0;
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = D_HOLD;
      m_hist[c].delete();
      m_out[c] = 1'b0;
      m_oe[c]  = 1'b0;
      m_int[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      dec_e raw, acc_old;
      bit   uniform;
      raw     = decide(m_p2[c], m_n2[c]);
      acc_old = m_acc[c];
      if (bus.en) begin
        m_hist[c].push_back(raw);
        if (m_hist[c].size() > FILT) void'(m_hist[c].pop_front());
        uniform = (m_hist[c].size() == FILT);
        for (int k = 0; k < m_hist[c].size(); k++)
          if (m_hist[c][k] != raw) uniform = 1'b0;
        if (uniform && raw != m_acc[c]) m_acc[c] = raw;
        if (m_acc[c] == D_HIGH)     m_out[c] = 1'b1;
        else if (m_acc[c] == D_LOW) m_out[c] = 1'b0;
        m_oe[c] = (m_acc[c] != D_HOLD);
      end
      if (bus.clr)     m_int[c] = 0;
      else if (bus.en) m_int[c] = int_step(m_int[c], acc_old);
    end
    m_p2 = m_p1; m_p1 = bus.vip;
    m_n2 = m_n1; m_n1 = bus.vin;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("mdl_out%0d", c),    int'(bus.out[c]),    int'(m_out[c]));
      check($sformatf("mdl_oe%0d", c),     int'(bus.out_en[c]), int'(m_oe[c]));
      check($sformatf("mdl_integ%0d", c),  integ_of(c),         m_int[c]);
      check($sformatf("mdl_sat%0d", c),    int'(bus.sat[c]),
            int'(m_int[c] == IMAX || m_int[c] == IMIN));
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_out"},   int'(bus.out),    0);
    check({name, "_oe"},    int'(bus.out_en), 0);
    check({name, "_integ"}, int'(bus.integ),  0);
    check({name, "_sat"},   int'(bus.sat),    0);
  endtask

  task automatic check_ch0(input string name, input int o, input int oe, input int i);
    check({name, "_out0"},   int'(bus.out[0]),    o);
    check({name, "_oe0"},    int'(bus.out_en[0]), oe);
    check({name, "_integ0"}, integ_of(0),         i);
  endtask

  // Drive inputs, take one clock edge, advance the model and compare 1 ns later.
  task automatic step(input logic [1:0] vp, input logic [1:0] vn, input logic e, input logic c);
    bus.vip = vp; bus.vin = vn; bus.en = e; bus.clr = c;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[44];
    int   e_int;
    dec_e acc_prev, acc_r;
    logic e_out;

    // Directed table from reset: drive high, glitch on ch1, hold, drive low.
    // acc changes 2+FILT edges after each input change (rows 1, 19, 25).
    e_int = 0; acc_prev = D_HOLD; e_out = 1'b0;
    for (int r = 1; r <= 44; r++) begin
      vec_t v;
      if (r <= 18)      begin v.vip = 2'b01; v.vin = (r == 13) ? 2'b10 : 2'b00; end
      else if (r <= 24) begin v.vip = 2'b01; v.vin = 2'b01; end
      else              begin v.vip = 2'b00; v.vin = 2'b01; end
      acc_r = (r < 4) ? D_HOLD : (r < 22) ? D_HIGH : (r < 28) ? D_HOLD : D_LOW;
      e_int = int_step(e_int, acc_prev);
      if (acc_r == D_HIGH)     e_out = 1'b1;
      else if (acc_r == D_LOW) e_out = 1'b0;
      v.out = {1'b0, e_out};
      v.oe  = {1'b0, acc_r != D_HOLD};
      v.sat = {1'b0, (e_int == IMAX) || (e_int == IMIN)};
      v.i0  = e_int;
      v.i1  = 0;
      tbl[r-1] = v;
      acc_prev = acc_r;
    end

    // Asynchronous reset before any clock edge, inputs random.
    bus.vip = 2'($urandom); bus.vin = 2'($urandom);
    bus.en  = 1'($urandom); bus.clr = 1'($urandom);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    for (int r = 0; r < 44; r++) begin
      step(tbl[r].vip, tbl[r].vin, 1'b1, 1'b0);
      check($sformatf("tbl%0d_out", r + 1),    int'(bus.out),    int'(tbl[r].out));
      check($sformatf("tbl%0d_oe", r + 1),     int'(bus.out_en), int'(tbl[r].oe));
      check($sformatf("tbl%0d_sat", r + 1),    int'(bus.sat),    int'(tbl[r].sat));
      check($sformatf("tbl%0d_integ0", r + 1), integ_of(0),      tbl[r].i0);
      check($sformatf("tbl%0d_integ1", r + 1), integ_of(1),      tbl[r].i1);
    end

    // Clear while running, count down, freeze with en=0, clear while frozen.
    step(2'b00, 2'b01, 1'b1, 1'b1); check_ch0("clr_run", 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      step(2'b00, 2'b01, 1'b1, 1'b0); check_ch0("cnt_low", 0, 1, -k);
    end
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 2'b00, 1'b0, 1'b0); check_ch0("en0_freeze", 0, 1, -3);
    end
    step(2'b01, 2'b00, 1'b0, 1'b1); check_ch0("clr_en0", 0, 1, 0);
    step(2'b01, 2'b00, 1'b1, 1'b0); check_ch0("resume1", 0, 1, -1);
    step(2'b01, 2'b00, 1'b1, 1'b0); check_ch0("resume2", 1, 1, -2);
    step(2'b01, 2'b00, 1'b1, 1'b0); check_ch0("resume3", 1, 1, -1);

    // Pending run interrupted by en=0 completes on the first enabled edge.
    step(2'b00, 2'b01, 1'b1, 1'b0); check_ch0("rc_a", 1, 1, 0);
    step(2'b00, 2'b01, 1'b1, 1'b0); check_ch0("rc_b", 1, 1, 1);
    step(2'b00, 2'b01, 1'b1, 1'b0); check_ch0("rc_pend", 1, 1, 2);
    step(2'b00, 2'b01, 1'b0, 1'b0); check_ch0("rc_held1", 1, 1, 2);
    step(2'b00, 2'b01, 1'b0, 1'b0); check_ch0("rc_held2", 1, 1, 2);
    step(2'b00, 2'b01, 1'b1, 1'b0); check_ch0("rc_accept", 0, 1, 3);

    // Mid-drive reset clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Randomized segments of held inputs with occasional en drops and clears.
    for (int seg = 0; seg < 120; seg++) begin
      logic [1:0] vp, vn;
      int         len;
      vp  = 2'($urandom);
      vn  = 2'($urandom);
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++)
        step(vp, vn, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/digi_ota_array.md
Name: digi_ota_array

Overview:
- Clocked, parametrised successor to the single-channel asynchronous digital OTA cell.
- Each of CH channels samples a differential digital pair (vip/vin) and resolves it to drive-high, drive-low or hold (tri-state with keeper). The output enable is explicit, because the pad cannot tri-state.
- Each channel integrates its drive into a saturating signed counter, the digital model of output charge.
- Sits behind ui_in pins in the top wrapper; results go to uo_out and uio.

Parameters:
- CH, 2, number of independent channels (>=1).
- CNT_W, 8, integrator width in bits, two's complement (>=2).
- FILT, 2, consecutive cycles a new decision must persist before acceptance (>=1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  1 = run; 0 = freeze filter, decision and integrator state.
- clr  input  1  synchronous clear of all integrators.
- vip  input  CH  non-inverting inputs, asynchronous to clk.
- vin  input  CH  inverting inputs, asynchronous to clk.
- out  output  CH  resolved output per channel (keeper value while not driving).
- out_en  output  CH  1 = channel actively driving.
- integ  output  CH*CNT_W  integrator values; channel i occupies bits [i*CNT_W +: CNT_W].
- sat  output  CH  1 while the integrator is at +max or -min.

Behaviour:
- Reset (async, rst_n=0): sync flops, filter state, out, out_en, integ and sat all 0; accepted decision = HOLD.
- Synchroniser: 2 flip-flops per vip/vin bit; always sampling, including while en=0.
- Raw decision per cycle, from the synchronised pair:
  - HOLD when vip_s==vin_s.
  - HIGH when vip_s=1, vin_s=0.
  - LOW when vip_s=0, vin_s=1.
- Filter: accepted decision acc and pending decision pend, with run counter rc (0..FILT-1).
  - raw==acc: rc<=0.
  - raw!=acc and raw!=pend: pend<=raw, rc<=0. If FILT==1, acc<=raw immediately.
  - raw==pend!=acc: rc increments; on the edge where the run length reaches FILT, acc<=raw and rc<=0.
- Outputs from acc, registered:
  - HIGH: out_en=1, out=1.
  - LOW: out_en=1, out=0.
  - HOLD: out_en=0, out keeps its last driven value.
- Pin-to-out latency: a pair change stable before edge 1 is visible on out/out_en after edge 2+FILT.
- Pulses shorter than FILT synchronised cycles never reach acc.
- Integrator, updated from acc one edge after out:
  - HIGH: +1.
  - LOW: -1.
  - HOLD: no change.
  - Saturates at 2^(CNT_W-1)-1 and -2^(CNT_W-1); never wraps.
  - sat is combinational from integ (1 when integ equals either limit).
- Priority, highest first:
  1. rst_n.
  2. clr: integ<=0 on the next edge, even when en=0; out/acc unaffected.
  3. en=0: filter, acc, out, out_en and integ hold.
  4. Normal operation.
- Re-asserting en resumes with rc continuing from its held value.
- A mid-operation reset asynchronously forces every output to 0.
- Channels are fully independent; identical stimulus gives identical per-channel timing.

Optional Feature:
- DIGI_OTA_LEAK_EN defined: while acc==HOLD and en=1, integ moves one step toward 0 every edge and stops at 0 (models output leakage); clr still has priority.
- Undefined: integ holds on HOLD.
- Port list is identical either way.

Test Plan (CH=2, CNT_W=4, FILT=2, leak off unless stated):
- Reset: rst_n=0 with random inputs -> out=00, out_en=00, integ=0x00, sat=00; all asynchronous, before any clk edge.
- Drive high: ch0 vip=1/vin=0 held.
  - out_en[0]=1, out[0]=1 after edge 4.
  - integ[3:0] counts 1..7 from edge 5, then holds 7 with sat[0]=1.
  - ch1 unchanged.
- Glitch reject: ch1 vin=1 for one clk cycle only -> out_en[1] stays 0, integ[7:4] stays 0.
- Hold/keeper: after drive high, set ch0 vip=vin=1 -> out_en[0]=0 after edge 4, out[0] stays 1, integ holds 7.
- Drive low to saturation: ch0 vip=0/vin=1 for 20 cycles -> out[0]=0, integ[3:0] reaches 0x8 (-8) and stays there, sat[0]=1.
- Controls:
  - en=0 mid-count freezes integ; clr=1 with en=0 zeroes integ next edge.
  - rst_n pulse mid-drive forces all outputs to 0 immediately.
  - With DIGI_OTA_LEAK_EN, HOLD from integ=5 decays 4,3,2,1,0 and stops.
